// File: rtl/cov_pkg.sv
// Shared types and helpers for the streaming covariance block: FSM states,
// pair-index mapping over the upper triangle, and the scale/saturate step.
package cov_pkg;

  typedef enum logic [2:0] {IDLE, WAIT, MAC, SCALE, DONE} cov_state_e;

  localparam int MAX_CH = 8;
  localparam int SAT_W  = 128;

  typedef struct packed {
    logic signed [SAT_W-1:0] val;
    logic                    clip;
  } sat_res_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic int num_pairs(input int n);
    return n * (n + 1) / 2;
  endfunction

  // Product of two DATA_W samples summed over 2^l2 samples never overflows.
  function automatic int acc_width(input int dw, input int l2);
    return 2 * dw + l2;
  endfunction

  // Pair order: (0,0),(0,1)..(0,n-1),(1,1)..(n-1,n-1).
  function automatic int pair_to_i(input int p, input int n);
    int k, r;
    k = 0;
    r = 0;
    for (int i = 0; i < MAX_CH; i++)
      for (int j = 0; j < MAX_CH; j++)
        if (i < n && j >= i && j < n) begin
          if (k == p) r = i;
          k++;
        end
    return r;
  endfunction

  function automatic int pair_to_j(input int p, input int n);
    int k, r;
    k = 0;
    r = 0;
    for (int i = 0; i < MAX_CH; i++)
      for (int j = 0; j < MAX_CH; j++)
        if (i < n && j >= i && j < n) begin
          if (k == p) r = j;
          k++;
        end
    return r;
  endfunction

  // Arithmetic right shift (floor) followed by clipping to a dw-bit signed range.
  function automatic sat_res_t shift_sat(input logic signed [SAT_W-1:0] acc,
                                         input int sh, input int dw);
    sat_res_t                r;
    logic signed [SAT_W-1:0] v, hi, lo;
    v      = acc >>> sh;
    hi     = (128'sd1 <<< (dw - 1)) - 128'sd1;
    lo     = -(128'sd1 <<< (dw - 1));
    r.clip = 1'b0;
    r.val  = v;
    if (v > hi) begin
      r.val  = hi;
      r.clip = 1'b1;
    end else if (v < lo) begin
      r.val  = lo;
      r.clip = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cov_mac.sv
// Shared multiply-accumulate: registered signed product, then accumulate into
// one of P accumulators. The product retires one cycle after it is issued.
module cov_mac
  import cov_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int P      = 10,
  parameter int PW     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     en,
  input  logic [PW-1:0]            idx,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic [PW-1:0]            rd_idx,
  output logic signed [ACC_W-1:0]  rd_acc
);

  logic signed [2*DATA_W-1:0] prod_p0;
  logic [PW-1:0]              idx_p0;
  logic                       vld_p0;
  logic signed [ACC_W-1:0]    acc_q [P];

  // Stage p0: product register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      idx_p0  <= '0;
      prod_p0 <= '0;
    end else begin
      vld_p0  <= en && !clr;
      idx_p0  <= idx;
      prod_p0 <= a * b;
    end
  end

  // Stage p1: accumulate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < P; p++) acc_q[p] <= '0;
    end else if (clr) begin
      for (int p = 0; p < P; p++) acc_q[p] <= '0;
    end else if (vld_p0) begin
      acc_q[idx_p0] <= acc_q[idx_p0] + ACC_W'(prod_p0);
    end
  end

  assign rd_acc = acc_q[rd_idx];

endmodule

// File: rtl/covariance_stream.sv
// Streaming N_CH x N_CH covariance over 2^LOG2_SAMPLES centred samples.
// Per sample: 1 accept + P MAC cycles; last accept to cov_valid = 2*P+1 cycles.
module covariance_stream
  import cov_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int DATA_W       = 16,
  parameter int LOG2_SAMPLES = 8,
  parameter int FRAC_SHIFT   = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_CH*DATA_W-1:0]        in_data,
  output logic [N_CH*N_CH*DATA_W-1:0]   cov_flat,
  output logic                          cov_valid,
  output logic                          busy,
  output logic                          sat
);

  localparam int P     = num_pairs(N_CH);
  localparam int PW    = clog2(P);
  localparam int ACC_W = acc_width(DATA_W, LOG2_SAMPLES);
  localparam int SH    = LOG2_SAMPLES + FRAC_SHIFT;
  localparam logic [PW-1:0]         LAST_PAIR = PW'(P - 1);
  localparam logic [LOG2_SAMPLES:0] LAST_SMP  = (LOG2_SAMPLES + 1)'((1 << LOG2_SAMPLES) - 1);

  logic [1:0]                        rst_sync_q;
  logic                              rst_ni;
  cov_state_e                        state_q, state_d;
  logic [PW-1:0]                     pair_q, pair_d;
  logic [LOG2_SAMPLES:0]             cnt_q, cnt_d;
  logic                              sat_q, sat_d;
  logic [N_CH*DATA_W-1:0]            x_q;
  logic signed [DATA_W-1:0]          res_q [P];
  logic [N_CH*N_CH*DATA_W-1:0]       cov_q, cov_d;
  logic                              clr, accept;
  int                                ix, jx;
  logic signed [DATA_W-1:0]          a_op, b_op, sval, elem;
  logic signed [ACC_W-1:0]           rd_acc;
  sat_res_t                          sres;

  // Reset asserts asynchronously, releases on the clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_ni = rst_sync_q[1];

  always_comb begin
    state_d = state_q;
    pair_d  = pair_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    clr     = 1'b0;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        clr     = 1'b1;
        cnt_d   = '0;
        sat_d   = 1'b0;
        state_d = WAIT;
      end
      WAIT: if (in_valid) begin
        accept  = 1'b1;
        pair_d  = '0;
        state_d = MAC;
      end
      MAC: begin
        pair_d = pair_q + 1'b1;
        if (pair_q == LAST_PAIR) begin
          pair_d  = '0;
          cnt_d   = cnt_q + 1'b1;
          state_d = (cnt_q == LAST_SMP) ? SCALE : WAIT;
        end
      end
      SCALE: begin
        pair_d = pair_q + 1'b1;
        if (sres.clip) sat_d = 1'b1;
        if (pair_q == LAST_PAIR) begin
          pair_d  = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (start) begin
          clr     = 1'b1;
          cnt_d   = '0;
          sat_d   = 1'b0;
          state_d = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      pair_q  <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      x_q     <= '0;
    end else begin
      state_q <= state_d;
      pair_q  <= pair_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      if (accept) x_q <= in_data;
    end
  end

  always_comb begin
    ix   = pair_to_i(int'(pair_q), N_CH);
    jx   = pair_to_j(int'(pair_q), N_CH);
    a_op = x_q[ix*DATA_W +: DATA_W];
    b_op = x_q[jx*DATA_W +: DATA_W];
  end

  // The final product lands while SCALE reads pair 0, so no extra cycle is needed.
  cov_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .P      (P),
    .PW     (PW)
  ) u_mac (
    .clk    (clk),
    .rst_n  (rst_ni),
    .clr    (clr),
    .en     (state_q == MAC),
    .idx    (pair_q),
    .a      (a_op),
    .b      (b_op),
    .rd_idx (pair_q),
    .rd_acc (rd_acc)
  );

  always_comb begin
    sres = shift_sat(SAT_W'(rd_acc), SH, DATA_W);
    sval = sres.val[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int p = 0; p < P; p++) res_q[p] <= '0;
    end else if (state_q == SCALE) begin
      res_q[pair_q] <= sval;
    end
  end

  // The visible matrix switches atomically on the last SCALE cycle.
  always_comb begin
    cov_d = cov_q;
    elem  = '0;
    if (state_q == SCALE && pair_q == LAST_PAIR) begin
      for (int p = 0; p < P; p++) begin
        elem = (p == P - 1) ? sval : res_q[p];
        cov_d[(pair_to_i(p, N_CH)*N_CH + pair_to_j(p, N_CH))*DATA_W +: DATA_W] = elem;
        cov_d[(pair_to_j(p, N_CH)*N_CH + pair_to_i(p, N_CH))*DATA_W +: DATA_W] = elem;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) cov_q <= '0;
    else         cov_q <= cov_d;
  end

  assign cov_flat  = cov_q;
  assign cov_valid = (state_q == DONE);
  assign busy      = (state_q == WAIT) || (state_q == MAC) || (state_q == SCALE);
  assign in_ready  = (state_q == WAIT);
  assign sat       = sat_q;

endmodule

// File: tb/tb_covariance_stream.sv
// Scoreboard bench for covariance_stream (N_CH=4, DATA_W=16, 4-sample blocks).
module tb_covariance_stream;

  localparam int NCH = 4;
  localparam int DW  = 16;
  localparam int L2  = 2;
  localparam int NS  = 1 << L2;
  localparam int P   = NCH * (NCH + 1) / 2;
  localparam int FW  = NCH * NCH * DW;

  typedef struct {
    logic [FW-1:0] flat;
    logic          sat;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic            in_valid;
  logic            in_ready;
  logic [NCH*DW-1:0] in_data;
  logic [FW-1:0]   cov_flat;
  logic            cov_valid;
  logic            busy;
  logic            sat;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  exp_t exp_q[$];

  covariance_stream #(
    .N_CH         (NCH),
    .DATA_W       (DW),
    .LOG2_SAMPLES (L2),
    .FRAC_SHIFT   (0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .cov_flat  (cov_flat),
    .cov_valid (cov_valid),
    .busy      (busy),
    .sat       (sat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Reference model: block covariance from plain sums, floor division, clipping.
  function automatic exp_t model(input int x[NS][NCH]);
    exp_t   e;
    longint s, q;
    e.flat = '0;
    e.sat  = 1'b0;
    for (int i = 0; i < NCH; i++)
      for (int j = 0; j < NCH; j++) begin
        s = 0;
        for (int n = 0; n < NS; n++) s += longint'(x[n][i]) * longint'(x[n][j]);
        q = (s >= 0) ? s / NS : -((-s + NS - 1) / NS);
        if (q > 32767) begin
          q = 32767;
          e.sat = 1'b1;
        end else if (q < -32768) begin
          q = -32768;
          e.sat = 1'b1;
        end
        e.flat[(i*NCH+j)*DW +: DW] = DW'(q);
      end
    return e;
  endfunction

  // Monitor: handshake spacing, pulse shape, latency, result and hold checks.
  int            acc_cnt, last_acc;
  bit            have_acc, prev_cv;
  logic [FW-1:0] last_flat;
  exp_t          mon_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      acc_cnt   = 0;
      have_acc  = 0;
      prev_cv   = 0;
      last_flat = '0;
    end else begin
      if (in_valid && in_ready) begin
        if (have_acc) chk("accept_gap_ge_P_plus_1", FW'(cyc - last_acc >= P + 1), FW'(1));
        last_acc = cyc;
        have_acc = 1;
        acc_cnt++;
      end
      if (cov_valid) begin
        chk("cov_valid_single_pulse", FW'(prev_cv), FW'(0));
        chk("busy_low_at_done", FW'(busy), FW'(0));
        chk("accepts_per_block", FW'(acc_cnt), FW'(NS));
        chk("last_accept_to_valid", FW'(cyc - last_acc), FW'(2 * P + 1));
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_cov_valid: got a result, expected none");
        end else begin
          mon_e = exp_q.pop_front();
          chk("cov_flat", cov_flat, mon_e.flat);
          chk("sat", FW'(sat), FW'(mon_e.sat));
        end
        last_flat = cov_flat;
        acc_cnt   = 0;
      end else begin
        chk("cov_flat_hold", cov_flat, last_flat);
      end
      prev_cv = cov_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_sample(input logic [NCH*DW-1:0] v, input bit hold);
    bit r;
    int t;
    in_valid = 1'b1;
    in_data  = v;
    t = 0;
    r = 0;
    while (!r && t < 200) begin
      @(negedge clk);
      r = in_ready;
      tick();
      t++;
    end
    if (!r) timeout("sample_accept");
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready && t < 200);
    if (!in_ready) timeout("wait_ready");
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (busy && t < 300);
    if (busy) timeout("wait_idle");
    tick();
  endtask

  task automatic wait_valid();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!cov_valid && t < 300);
    if (!cov_valid) timeout("wait_valid");
  endtask

  function automatic int rnd(input int kind, input int n, input int k);
    logic signed [DW-1:0] r16;
    r16 = DW'($urandom);
    case (kind)
      0: return k + 1;
      1: return int'($urandom_range(2000)) - 1000;
      2: return int'(r16);
      3: return -32768;
      4: return (k % 2 == 0) ? 300 : -300;
      5: return 1;
      default: return (n % 2 == 0) ? 32767 : -32768;
    endcase
  endfunction

  task automatic run_block(input int kind, input bit need_start, input bit hold,
                           input bit mid_start, input bit chain);
    int            x[NS][NCH];
    logic [NCH*DW-1:0] v;
    for (int n = 0; n < NS; n++)
      for (int k = 0; k < NCH; k++) x[n][k] = rnd(kind, n, k);
    if (need_start) begin
      pulse_start();
      chk("sat_cleared_by_start", FW'(sat), FW'(0));
      chk("busy_after_start", FW'(busy), FW'(1));
    end
    for (int n = 0; n < NS; n++) begin
      if (mid_start && n == 2) begin
        wait_ready();
        pulse_start();
      end
      for (int k = 0; k < NCH; k++) v[k*DW +: DW] = DW'(x[n][k]);
      send_sample(v, hold && n < NS - 1);
    end
    exp_q.push_back(model(x));
    if (mid_start) begin
      repeat (P + 5) tick();
      pulse_start();
    end
    if (chain) begin
      wait_valid();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("wait_right_after_done_start", FW'(in_ready), FW'(1));
    end else begin
      wait_idle();
    end
  endtask

  initial begin
    rst_n    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_cov_flat", cov_flat, '0);
    chk("reset_cov_valid", FW'(cov_valid), FW'(0));
    chk("reset_busy", FW'(busy), FW'(0));
    chk("reset_sat", FW'(sat), FW'(0));
    chk("reset_in_ready", FW'(in_ready), FW'(0));
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();

    in_valid = 1'b1;
    in_data  = {4{16'sd7}};
    repeat (3) begin
      @(negedge clk);
      chk("idle_in_ready_low", FW'(in_ready), FW'(0));
      chk("idle_busy_low", FW'(busy), FW'(0));
    end
    tick();
    in_valid = 1'b0;

    run_block(0, 1, 0, 0, 0);
    run_block(4, 1, 0, 0, 0);
    run_block(5, 1, 0, 0, 0);
    run_block(1, 1, 1, 0, 0);
    run_block(0, 1, 0, 1, 0);
    run_block(2, 1, 0, 0, 1);
    run_block(3, 0, 0, 0, 0);
    run_block(6, 1, 1, 0, 0);

    pulse_start();
    for (int n = 0; n < 3; n++) send_sample(NCH*DW'($urandom), 0);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_cov_flat", cov_flat, '0);
    chk("midreset_busy", FW'(busy), FW'(0));
    chk("midreset_in_ready", FW'(in_ready), FW'(0));
    chk("midreset_cov_valid", FW'(cov_valid), FW'(0));
    chk("midreset_sat", FW'(sat), FW'(0));
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    run_block(0, 1, 0, 0, 0);

    for (int b = 0; b < 4; b++) run_block(1 + (b % 2), 1, b >= 2, 0, 0);

    repeat (5) tick();
    chk("scoreboard_drained", FW'(exp_q.size()), FW'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1);
  end

endmodule
